lattice_scheduler: RTL and testbench

Work sequencer at the head and tail of the mining-core lattice chain. It accepts one block job (midstate plus header tail) from the host and issues it into the lattice once per cycle. Each issue carries a nonce base that advances by NUM_CORES per issue. It pairs each result leaving the chain with the base it was issued with, reports the first winning nonce, and stops issuing on a win, on nonce-space exhaustion, or when a new job preempts the current one.

---
 rtl/lattice_scheduler.sv | 226 ++++++++++++++++++++++
 tb/tb_lattice_scheduler.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lattice_scheduler.sv
// lattice_scheduler
// Sequencer at the head and tail of the mining-core lattice chain. It takes
// one block job from the host and issues it into the lattice once per cycle.
// Each issue carries a nonce base that advances by 2^LOG2_NUM_CORES. Results
// leave the chain in issue order. Each result is paired with its base through
// an in-flight tag FIFO, so the first winning nonce of the current job can be
// reported.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   work_valid_i/_o    host job handshake (work_ready_o low only in LOAD)
//   work_state_i       352-bit job word; low 32 bits replaced by nonce base
//   halt_i             pauses issuing only
//   validIn_o, newBlockIn_o, initialStateIn_o   registered lattice issue
//   validOut_i, newBlockOut_i, success_i, nonce_index_i   chain-end result
//   found_valid_o, found_nonce_o   one-cycle pulse + held winning nonce
//   exhausted_o        one-cycle pulse when nonce space ends without a win
//   busy_o             scheduler not idle
//   err_o              sticky result-protocol error
module lattice_scheduler #(
  parameter int LOG2_NUM_CORES = 4,
  parameter int LOG2_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      work_valid_i,
  output logic                      work_ready_o,
  input  logic [351:0]              work_state_i,
  input  logic                      halt_i,
  output logic                      validIn_o,
  output logic                      newBlockIn_o,
  output logic [351:0]              initialStateIn_o,
  input  logic                      validOut_i,
  input  logic                      newBlockOut_i,
  input  logic                      success_i,
  input  logic [LOG2_NUM_CORES-1:0] nonce_index_i,
  output logic                      found_valid_o,
  output logic [31:0]               found_nonce_o,
  output logic                      exhausted_o,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam int          DEPTH     = 1 << LOG2_DEPTH;
  localparam logic [31:0] STEP      = 32'(1) << LOG2_NUM_CORES;
  localparam logic [31:0] LAST_BASE = 32'(0) - STEP;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_e;

  typedef struct packed {
    logic        epoch;
    logic        first;
    logic [31:0] base;
  } tag_t;

  state_e                state_q, state_d;
  logic [351:32]         job_q, job_d;
  logic [31:0]           base_q, base_d;
  logic                  epoch_q, epoch_d;
  logic                  found_q, found_d;
  logic                  exhaust_q, exhaust_d;
  logic                  err_q, err_d;
  logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG2_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOG2_DEPTH:0]   count_q, count_d;
  logic                  valid_q, valid_d;
  logic                  newblk_q, newblk_d;
  logic [351:0]          istate_q, istate_d;
  logic                  fvalid_q, fvalid_d;
  logic [31:0]           fnonce_q, fnonce_d;
  logic                  exh_out_q, exh_out_d;
  tag_t                  fifo_q [DEPTH];

  logic accept, pop, push, win, fifo_empty, fifo_full;
  tag_t head;

  // The low job word is always overwritten by the nonce base.
  logic unused_low_word;
  assign unused_low_word = ^work_state_i[31:0];

  assign work_ready_o     = (state_q != LOAD);
  assign busy_o           = (state_q != IDLE);
  assign validIn_o        = valid_q;
  assign newBlockIn_o     = newblk_q;
  assign initialStateIn_o = istate_q;
  assign found_valid_o    = fvalid_q;
  assign found_nonce_o    = fnonce_q;
  assign exhausted_o      = exh_out_q;
  assign err_o            = err_q;

  // Handshake, FIFO status and issue decision. An accepted job takes the
  // cycle, and a current-epoch win in RUN suppresses the issue. The full
  // test uses the count before any same-cycle pop.
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (LOG2_DEPTH+1)'(DEPTH));
  assign head       = fifo_q[rd_ptr_q];
  assign accept     = work_valid_i && (state_q != LOAD);
  assign pop        = validOut_i && !fifo_empty;
  assign win        = pop && (head.epoch == epoch_q) && success_i && !found_q;
  assign push       = ((state_q == LOAD) || (state_q == RUN)) && !halt_i &&
                      !fifo_full && !accept && !((state_q == RUN) && win);

  // Next-state logic for the FSM, the job/base/epoch bookkeeping and the
  // registered outputs. A job accept is applied last so that it overrides
  // every other transition and flag update made in the same cycle.
  always_comb begin
    state_d   = state_q;
    job_d     = job_q;
    base_d    = base_q;
    epoch_d   = epoch_q;
    found_d   = found_q;
    exhaust_d = exhaust_q;
    err_d     = err_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    valid_d   = 1'b0;
    newblk_d  = 1'b0;
    istate_d  = istate_q;
    fvalid_d  = 1'b0;
    fnonce_d  = fnonce_q;
    exh_out_d = 1'b0;

    if ((validOut_i && fifo_empty) || (pop && (newBlockOut_i != head.first))) begin
      err_d = 1'b1;
    end

    if (win) begin
      fvalid_d = 1'b1;
      fnonce_d = head.base + 32'(nonce_index_i);
      found_d  = 1'b1;
    end

    if (push) begin
      valid_d  = 1'b1;
      newblk_d = (state_q == LOAD);
      istate_d = {job_q, base_q};
      base_d   = base_q + STEP;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    count_d = count_q + (LOG2_DEPTH+1)'(push) - (LOG2_DEPTH+1)'(pop);

    case (state_q)
      LOAD: begin
        if (push) state_d = RUN;
      end
      RUN: begin
        if (win) begin
          state_d = DRAIN;
        end else if (push && (base_q == LAST_BASE)) begin
          exhaust_d = 1'b1;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        if (count_d == '0) begin
          state_d   = IDLE;
          exh_out_d = exhaust_q && !found_q && !win;
        end
      end
      default: ;
    endcase

    if (accept) begin
      state_d   = LOAD;
      job_d     = work_state_i[351:32];
      base_d    = '0;
      epoch_d   = ~epoch_q;
      found_d   = 1'b0;
      exhaust_d = 1'b0;
      exh_out_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      job_q     <= '0;
      base_q    <= '0;
      epoch_q   <= 1'b0;
      found_q   <= 1'b0;
      exhaust_q <= 1'b0;
      err_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      newblk_q  <= 1'b0;
      istate_q  <= '0;
      fvalid_q  <= 1'b0;
      fnonce_q  <= '0;
      exh_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      job_q     <= job_d;
      base_q    <= base_d;
      epoch_q   <= epoch_d;
      found_q   <= found_d;
      exhaust_q <= exhaust_d;
      err_q     <= err_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      newblk_q  <= newblk_d;
      istate_q  <= istate_d;
      fvalid_q  <= fvalid_d;
      fnonce_q  <= fnonce_d;
      exh_out_q <= exh_out_d;
    end
  end

  // Tag storage. Contents need no reset because the pointers and the count
  // define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= {epoch_q, (state_q == LOAD), base_q};
    end
  end

endmodule

// File: tb/tb_lattice_scheduler.sv
// Testbench for lattice_scheduler. The main instance uses the default
// parameters. A second instance with 2^28 cores per issue reaches the end of
// the nonce space in 16 issues, so the exhaustion path can be run quickly.
module tb_lattice_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         workValid, workReady, halt;
  logic [351:0] workState;
  logic         validIn, newBlockIn;
  logic [351:0] initialStateIn;
  logic         validOut, newBlockOut, success;
  logic [3:0]   nonceIdx;
  logic         foundValid, exhausted, busy, err;
  logic [31:0]  foundNonce;

  logic         xWorkValid, xWorkReady, xValidIn, xNewBlockIn;
  logic [351:0] xInitialStateIn;
  logic         xValidOut, xNewBlockOut, xSuccess;
  logic [27:0]  xNonceIdx;
  logic         xFoundValid, xExhausted, xBusy, xErr;
  logic [31:0]  xFoundNonce;

  int assertions = 0;
  int failures   = 0;

  lattice_scheduler dut (
    .clk(clk), .rst(rst),
    .work_valid_i(workValid), .work_ready_o(workReady), .work_state_i(workState),
    .halt_i(halt),
    .validIn_o(validIn), .newBlockIn_o(newBlockIn), .initialStateIn_o(initialStateIn),
    .validOut_i(validOut), .newBlockOut_i(newBlockOut), .success_i(success),
    .nonce_index_i(nonceIdx),
    .found_valid_o(foundValid), .found_nonce_o(foundNonce),
    .exhausted_o(exhausted), .busy_o(busy), .err_o(err)
  );

  lattice_scheduler #(.LOG2_NUM_CORES(28), .LOG2_DEPTH(4)) exhDut (
    .clk(clk), .rst(rst),
    .work_valid_i(xWorkValid), .work_ready_o(xWorkReady), .work_state_i(workState),
    .halt_i(1'b0),
    .validIn_o(xValidIn), .newBlockIn_o(xNewBlockIn), .initialStateIn_o(xInitialStateIn),
    .validOut_i(xValidOut), .newBlockOut_i(xNewBlockOut), .success_i(xSuccess),
    .nonce_index_i(xNonceIdx),
    .found_valid_o(xFoundValid), .found_nonce_o(xFoundNonce),
    .exhausted_o(xExhausted), .busy_o(xBusy), .err_o(xErr)
  );

  typedef struct {
    bit          wv, hlt, vo, nbo, succ;
    logic [3:0]  idx;
    bit          eValid, eNb;
    logic [31:0] eBase;
    bit          eFound;
    logic [31:0] eNonce;
    bit          eBusy, eReady;
  } vec_t;

  typedef struct {
    int          jobId;
    logic [31:0] base;
    bit          first;
  } tag_t;

  tag_t lat[$];

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit wv, input bit hlt, input bit vo,
                               input bit nbo, input bit succ, input logic [3:0] idx);
    workValid   = wv;
    halt        = hlt;
    validOut    = vo;
    newBlockOut = nbo;
    success     = succ;
    nonceIdx    = idx;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic newJob();
    for (int k = 0; k < 11; k++) workState[k*32 +: 32] = $urandom();
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 4'd0);
    xWorkValid = 0; xValidOut = 0; xNewBlockOut = 0; xSuccess = 0; xNonceIdx = '0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // Cycle-exact table for the basic win: five issues, win on the third result.
  task automatic tableTest();
    vec_t vecs[10];
    logic [351:0] job;
    vecs[0] = '{1,0,0,0,0,4'd0, 0,0,32'd0,  0,32'd0,    1,0};
    vecs[1] = '{0,0,0,0,0,4'd0, 1,1,32'd0,  0,32'd0,    1,1};
    vecs[2] = '{0,0,0,0,0,4'd0, 1,0,32'd16, 0,32'd0,    1,1};
    vecs[3] = '{0,0,0,0,0,4'd0, 1,0,32'd32, 0,32'd0,    1,1};
    vecs[4] = '{0,0,1,1,0,4'd0, 1,0,32'd48, 0,32'd0,    1,1};
    vecs[5] = '{0,0,1,0,0,4'd0, 1,0,32'd64, 0,32'd0,    1,1};
    vecs[6] = '{0,0,1,0,1,4'd5, 0,0,32'd0,  1,32'h25,   1,1};
    vecs[7] = '{0,0,1,0,0,4'd0, 0,0,32'd0,  0,32'd0,    1,1};
    vecs[8] = '{0,0,1,0,1,4'd2, 0,0,32'd0,  0,32'd0,    0,1};
    vecs[9] = '{0,0,0,0,0,4'd0, 0,0,32'd0,  0,32'd0,    0,1};
    newJob();
    job = workState;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].wv, vecs[i].hlt, vecs[i].vo, vecs[i].nbo, vecs[i].succ, vecs[i].idx);
      tick();
      checkOutput($sformatf("tbl%0d.validIn", i), 64'(validIn), 64'(vecs[i].eValid));
      if (vecs[i].eValid) begin
        checkOutput($sformatf("tbl%0d.newBlock", i), 64'(newBlockIn), 64'(vecs[i].eNb));
        checkOutput($sformatf("tbl%0d.base", i), 64'(initialStateIn[31:0]), 64'(vecs[i].eBase));
        checkOutput($sformatf("tbl%0d.jobWord", i), 64'(initialStateIn[351:32] == job[351:32]), 64'd1);
      end
      checkOutput($sformatf("tbl%0d.found", i), 64'(foundValid), 64'(vecs[i].eFound));
      if (vecs[i].eFound)
        checkOutput($sformatf("tbl%0d.nonce", i), 64'(foundNonce), 64'(vecs[i].eNonce));
      checkOutput($sformatf("tbl%0d.busy", i), 64'(busy), 64'(vecs[i].eBusy));
      checkOutput($sformatf("tbl%0d.ready", i), 64'(workReady), 64'(vecs[i].eReady));
      checkOutput($sformatf("tbl%0d.err", i), 64'(err), 64'd0);
      checkOutput($sformatf("tbl%0d.exhausted", i), 64'(exhausted), 64'd0);
    end
    checkOutput("tbl.nonceHeld", 64'(foundNonce), 64'h25);
  endtask

  // With no results returned the scheduler fills the 16 tag slots and stalls;
  // one result frees exactly one slot.
  task automatic fifoFullTest();
    int issues = 0;
    doReset();
    newJob();
    applyStimulus(1, 0, 0, 0, 0, 4'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 4'd0);
    repeat (25) begin
      tick();
      if (validIn) issues++;
    end
    checkOutput("full.issues", 64'(issues), 64'd16);
    applyStimulus(0, 0, 1, 1, 0, 4'd0);
    tick();
    if (validIn) issues++;
    applyStimulus(0, 0, 0, 0, 0, 4'd0);
    repeat (5) begin
      tick();
      if (validIn) issues++;
    end
    checkOutput("full.oneMore", 64'(issues), 64'd17);
    checkOutput("full.err", 64'(err), 64'd0);
  endtask

  // A new job preempts six in-flight issues whose results all claim success.
  task automatic preemptTest();
    int issues = 0;
    int founds = 0;
    bit seenB = 0;
    logic [351:0] jobB;
    doReset();
    newJob();
    applyStimulus(1, 0, 0, 0, 0, 4'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 4'd0);
    for (int c = 0; c < 20 && issues < 6; c++) begin
      tick();
      if (validIn) issues++;
    end
    checkOutput("pre.sixIssued", 64'(issues), 64'd6);
    newJob();
    jobB = workState;
    applyStimulus(1, 1, 0, 0, 0, 4'd0);
    tick();
    checkOutput("pre.loadReady", 64'(workReady), 64'd0);
    checkOutput("pre.noIssueHalted", 64'(validIn), 64'd0);
    for (int k = 0; k < 10; k++) begin
      if (k < 6) applyStimulus(0, 0, 1, (k == 0), 1, 4'(k));
      else       applyStimulus(0, 0, 0, 0, 0, 4'd0);
      tick();
      if (foundValid) founds++;
      if (validIn && !seenB) begin
        seenB = 1;
        checkOutput("pre.firstNewBlock", 64'(newBlockIn), 64'd1);
        checkOutput("pre.firstBase", 64'(initialStateIn[31:0]), 64'd0);
        checkOutput("pre.jobB", 64'(initialStateIn[351:32] == jobB[351:32]), 64'd1);
      end
    end
    checkOutput("pre.newJobIssued", 64'(seenB), 64'd1);
    checkOutput("pre.noStaleFound", 64'(founds), 64'd0);
    checkOutput("pre.err", 64'(err), 64'd0);
  endtask

  task automatic errorTest();
    bit seen = 0;
    doReset();
    applyStimulus(0, 0, 1, 0, 0, 4'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 4'd0);
    checkOutput("err.emptyPop", 64'(err), 64'd1);
    repeat (3) tick();
    checkOutput("err.sticky", 64'(err), 64'd1);
    doReset();
    checkOutput("err.clearedByRst", 64'(err), 64'd0);
    newJob();
    applyStimulus(1, 0, 0, 0, 0, 4'd0);
    tick();
    applyStimulus(0, 1, 0, 0, 0, 4'd0);
    tick();
    checkOutput("err.firstIssue", 64'(validIn), 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 4'd0);
    for (int c = 0; c < 5 && !seen; c++) begin
      tick();
      if (validIn) seen = 1;
    end
    checkOutput("err.issueSeen", 64'(seen), 64'd1);
    applyStimulus(0, 1, 1, 0, 0, 4'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 4'd0);
    checkOutput("err.badFirstFlag", 64'(err), 64'd1);
  endtask

  // Randomized run against a job-level model: the n-th issue of a job carries
  // base 16*n, results return in issue order, and the first successful result
  // of the current job wins and ends issuing for that job.
  task automatic randomTest();
    int curJob = 0;
    int issued = 0;
    int phase = 0;
    int prevPhase;
    bit found = 0, loadPend = 0, sameJob;
    bit wv, hlt, vo, nbo, succ, winNow, expValid;
    logic [3:0] idx;
    logic [31:0] expBase, expNonce;
    logic [351:0] curWord = '0;
    doReset();
    lat.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      sameJob = 1;
      foreach (lat[k]) if (lat[k].jobId != curJob) sameJob = 0;
      wv = 0;
      if (!loadPend && sameJob) wv = (phase == 0) ? ($urandom % 4 == 0) : ($urandom % 40 == 0);
      hlt = ($urandom % 5 == 0);
      vo = (lat.size() > 0) && ((((cyc / 100) % 2) == 1) ? ($urandom % 4 == 0) : ($urandom % 4 != 0));
      nbo = vo ? lat[0].first : 1'b0;
      succ = vo && ($urandom % 6 == 0);
      idx = 4'($urandom);
      if (wv) newJob();
      winNow = vo && (lat[0].jobId == curJob) && succ && !found;
      expValid = (phase == 1) && !hlt && (lat.size() < 16) && !winNow && !wv;
      expBase = 32'(issued * 16);
      expNonce = vo ? lat[0].base + 32'(idx) : 32'd0;
      prevPhase = phase;
      applyStimulus(wv, hlt, vo, nbo, succ, idx);
      tick();
      checkOutput($sformatf("rnd%0d.validIn", cyc), 64'(validIn), 64'(expValid));
      if (expValid && validIn) begin
        checkOutput($sformatf("rnd%0d.newBlock", cyc), 64'(newBlockIn), 64'(loadPend));
        checkOutput($sformatf("rnd%0d.base", cyc), 64'(initialStateIn[31:0]), 64'(expBase));
        checkOutput($sformatf("rnd%0d.jobWord", cyc), 64'(initialStateIn[351:32] == curWord[351:32]), 64'd1);
      end
      checkOutput($sformatf("rnd%0d.found", cyc), 64'(foundValid), 64'(winNow));
      if (winNow) checkOutput($sformatf("rnd%0d.nonce", cyc), 64'(foundNonce), 64'(expNonce));
      checkOutput($sformatf("rnd%0d.err", cyc), 64'(err), 64'd0);
      checkOutput($sformatf("rnd%0d.exhausted", cyc), 64'(exhausted), 64'd0);
      if (vo) void'(lat.pop_front());
      if (winNow) begin
        found = 1;
        phase = 2;
      end
      if (expValid) begin
        lat.push_back('{curJob, expBase, loadPend});
        issued++;
        loadPend = 0;
      end
      if (prevPhase == 2 && lat.size() == 0) phase = 0;
      if (wv) begin
        curJob++;
        issued = 0;
        found = 0;
        loadPend = 1;
        phase = 1;
        curWord = workState;
      end
      checkOutput($sformatf("rnd%0d.busy", cyc), 64'(busy), 64'(phase != 0));
      checkOutput($sformatf("rnd%0d.ready", cyc), 64'(workReady), 64'(!loadPend));
    end
    applyStimulus(0, 0, 0, 0, 0, 4'd0);
  endtask

  // Exhaustion on the 2^28-core instance: bases 0, 0x10000000 ... 0xF0000000.
  task automatic exhaustTest(input bit winLast);
    int issues = 0, founds = 0, exhs = 0;
    logic [31:0] lastBase = '0, nonce = '0;
    bit busyAtExh = 1;
    logic [31:0] xq[$];
    bit xf[$];
    newJob();
    for (int cyc = 0; cyc < 60; cyc++) begin
      xWorkValid = (cyc == 0);
      xValidOut = 0; xNewBlockOut = 0; xSuccess = 0; xNonceIdx = 28'd3;
      if (xq.size() > 0 && (xq.size() >= 2 || issues == 16)) begin
        xValidOut = 1;
        xNewBlockOut = xf[0];
        xSuccess = winLast && (xq[0] == 32'hF000_0000);
        void'(xq.pop_front());
        void'(xf.pop_front());
      end
      tick();
      if (xValidIn) begin
        issues++;
        lastBase = xInitialStateIn[31:0];
        xq.push_back(xInitialStateIn[31:0]);
        xf.push_back(xNewBlockIn);
      end
      if (xFoundValid) begin
        founds++;
        nonce = xFoundNonce;
      end
      if (xExhausted) begin
        exhs++;
        busyAtExh = xBusy;
      end
    end
    xWorkValid = 0; xValidOut = 0; xSuccess = 0;
    checkOutput($sformatf("exh%0d.issues", winLast), 64'(issues), 64'd16);
    checkOutput($sformatf("exh%0d.lastBase", winLast), 64'(lastBase), 64'hF000_0000);
    checkOutput($sformatf("exh%0d.founds", winLast), 64'(founds), 64'(winLast));
    checkOutput($sformatf("exh%0d.pulses", winLast), 64'(exhs), 64'(!winLast));
    if (winLast) checkOutput("exh1.nonce", 64'(nonce), 64'hF000_0003);
    else         checkOutput("exh0.idleAtPulse", 64'(busyAtExh), 64'd0);
    checkOutput($sformatf("exh%0d.busyEnd", winLast), 64'(xBusy), 64'd0);
    checkOutput($sformatf("exh%0d.err", winLast), 64'(xErr), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    workState = '0;
    doReset();
    checkOutput("rst.ready", 64'(workReady), 64'd1);
    checkOutput("rst.busy", 64'(busy), 64'd0);
    checkOutput("rst.validIn", 64'(validIn), 64'd0);
    checkOutput("rst.newBlock", 64'(newBlockIn), 64'd0);
    checkOutput("rst.found", 64'(foundValid), 64'd0);
    checkOutput("rst.nonce", 64'(foundNonce), 64'd0);
    checkOutput("rst.exhausted", 64'(exhausted), 64'd0);
    checkOutput("rst.err", 64'(err), 64'd0);
    checkOutput("rst.xReady", 64'(xWorkReady), 64'd1);
    tableTest();
    fifoFullTest();
    preemptTest();
    errorTest();
    randomTest();
    doReset();
    exhaustTest(1'b0);
    exhaustTest(1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
